// File: rtl/stream_state_datapath_if.sv
// Stream bundle for stream_state_datapath: two input streams, state code, output stream.
// The master drives inputs and o_ready; the slave (datapath) drives the rest.
interface stream_state_datapath_if #(
    parameter int W  = 8,
    parameter int SW = 3
);
    logic [SW-1:0] state;
    logic [W-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          o_ready;

    modport master (
        output state, a_data, a_valid, b_data, b_valid, o_ready,
        input  a_ready, b_ready, o_data, o_valid
    );

    modport slave (
        input  state, a_data, a_valid, b_data, b_valid, o_ready,
        output a_ready, b_ready, o_data, o_valid
    );
endinterface

// File: rtl/stream_state_datapath.sv
// Joint a/b stream consumer; state selects the op, results queue in a DEPTH-entry FIFO.
// Optional accumulator (states 4/5) enabled by STREAM_STATE_DATAPATH_ACC_EN.
module stream_state_datapath #(
    parameter int W     = 8,
    parameter int SW    = 3,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    stream_state_datapath_if.slave s
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          space;
    logic          fire;
    logic          push;
    logic          pop;
    logic          emit;
    logic [W-1:0]  res;

`ifdef STREAM_STATE_DATAPATH_ACC_EN
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_sum;
    assign acc_sum = acc + s.a_data;
`endif

    assign s.o_valid = (count != '0);
    assign s.o_data  = s.o_valid ? mem[rptr] : '0;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop       = s.o_valid & s.o_ready;
    assign space     = (count < CW'(DEPTH)) | pop;
    assign s.a_ready = reset & s.b_valid & space;
    assign s.b_ready = reset & s.a_valid & space;
    assign fire      = reset & s.a_valid & s.b_valid & space;
    assign push      = fire & emit;

    always_comb begin
        emit = 1'b0;
        res  = '0;
        case (s.state)
            SW'(0): begin
                emit = 1'b1;
                res  = ((s.a_data == s.b_data) ? '0 : '1) ^ s.a_data;
            end
            SW'(1): begin
                emit = 1'b1;
            end
            SW'(2): begin
                emit = 1'b1;
                res  = '1;
            end
            SW'(3): begin
                emit = 1'b1;
                res  = s.a_data + s.b_data;
            end
`ifdef STREAM_STATE_DATAPATH_ACC_EN
            SW'(4): begin
                emit = 1'b1;
                res  = acc_sum;
            end
`endif
            default: begin
                emit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= res;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef STREAM_STATE_DATAPATH_ACC_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (fire && s.state == SW'(4)) begin
            acc <= acc_sum;
        end else if (fire && s.state == SW'(5)) begin
            acc <= '0;
        end
    end
`endif
endmodule
